key_event_decoder: RTL and testbench

Consumes the confirmed-press pulse from the button debounce filter and the raw active-low button level. Classifies each press as a short press or a long press, and optionally generates auto-repeat events while the button is held. Sits between the per-button debounce filter and the waveform/frequency control logic of the DDS function generator. All outputs are registered, one-cycle event pulses or levels.

---
 rtl/key_event_decoder.sv | 130 +++++++++++++
 tb/tb_key_event_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced presses as short/long, with optional auto-repeat
// Optional feature macro: KEY_AUTO_REPEAT_EN compiles in rep_cnt and repeat_press generation.
module key_event_decoder #(
   parameter logic [19:0] REL_CNT_MAX    = 20'd999_999,
   parameter logic [25:0] LONG_CNT_MAX   = 26'd49_999_999,
   parameter logic [23:0] REPEAT_CNT_MAX = 24'd9_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic button_in,
   input  logic key_flag,
   output logic short_press,
   output logic long_press,
   output logic repeat_press,
   output logic key_hold
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        btn_m, btn_s;
   logic [19:0] rel_cnt, rel_cnt_nxt;
   logic [25:0] hold_cnt, hold_cnt_nxt;
   logic        short_nxt, long_nxt, repeat_nxt;
   logic        rel_done;

   // button_in is asynchronous to sys_clk; idle level is released (1)
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         btn_m <= 1'b1;
         btn_s <= 1'b1;
      end else begin
         btn_m <= button_in;
         btn_s <= btn_m;
      end
   end

   assign rel_done = btn_s && (rel_cnt == REL_CNT_MAX);

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      rel_cnt_nxt  = rel_cnt;
      short_nxt    = 1'b0;
      long_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (key_flag) begin
               state_nxt    = PRESSED;
               hold_cnt_nxt = '0;
               rel_cnt_nxt  = '0;
            end
         end
         PRESSED: begin
            hold_cnt_nxt = hold_cnt + 26'd1;
            rel_cnt_nxt  = btn_s ? rel_cnt + 20'd1 : '0;
            // release wins a tie with the long threshold
            if (rel_done) begin
               state_nxt = IDLE;
               short_nxt = 1'b1;
            end else if (hold_cnt == LONG_CNT_MAX) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
            end
         end
         LONG: begin
            rel_cnt_nxt = btn_s ? rel_cnt + 20'd1 : '0;
            if (rel_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef KEY_AUTO_REPEAT_EN
   logic [23:0] rep_cnt, rep_cnt_nxt;

   always_comb begin
      rep_cnt_nxt = rep_cnt;
      repeat_nxt  = 1'b0;
      if (long_nxt) begin
         rep_cnt_nxt = '0;
      end else if (state == LONG) begin
         if (rep_cnt == REPEAT_CNT_MAX) begin
            rep_cnt_nxt = '0;
            // no repeat on the cycle the release is confirmed
            repeat_nxt  = !rel_done;
         end else begin
            rep_cnt_nxt = rep_cnt + 24'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt_nxt;
      end
   end
`else
   assign repeat_nxt = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         rel_cnt      <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_press <= 1'b0;
         key_hold     <= 1'b0;
      end else begin
         state        <= state_nxt;
         hold_cnt     <= hold_cnt_nxt;
         rel_cnt      <= rel_cnt_nxt;
         short_press  <= short_nxt;
         long_press   <= long_nxt;
         repeat_press <= repeat_nxt;
         key_hold     <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - self-checking bench for key_event_decoder against an event-level model
module tb_key_event_decoder;

   localparam int REL = 3;
   localparam int LNG = 20;
   localparam int REP = 5;
   localparam int N   = 600;
`ifdef KEY_AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b1;
   logic button_in = 1'b1;
   logic key_flag = 1'b0;
   logic short_press, long_press, repeat_press, key_hold;

   logic       stim_btn [N];
   logic       stim_kf  [N];
   logic       bs       [N];
   logic [3:0] obs      [N];
   logic [3:0] exp_o    [N];
   logic [3:0] rst_obs;
   int         n_cmp = 0;
   int         n_fail = 0;

   always #5 sys_clk = ~sys_clk;

   key_event_decoder #(
      .REL_CNT_MAX   (20'd3),
      .LONG_CNT_MAX  (26'd20),
      .REPEAT_CNT_MAX(24'd5)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .button_in   (button_in),
      .key_flag    (key_flag),
      .short_press (short_press),
      .long_press  (long_press),
      .repeat_press(repeat_press),
      .key_hold    (key_hold)
   );

   task automatic clear_stim();
      for (int c = 0; c < N; c++) begin
         stim_btn[c] = 1'b1;
         stim_kf[c]  = 1'b0;
      end
   endtask

   task automatic set_btn(input int from, input int to, input logic v);
      for (int c = from; c <= to && c < N; c++) stim_btn[c] = v;
   endtask

   // obs[c] = {short, long, repeat, hold} sampled mid-cycle c; cycle 0 follows reset release
   task automatic run_stim(input int n, input int rst_at);
      sys_rst_n = 1'b0;
      button_in = 1'b1;
      key_flag  = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      for (int c = 0; c < n; c++) begin
         button_in = stim_btn[c];
         key_flag  = stim_kf[c];
         if (c == rst_at) begin
            #2 sys_rst_n = 1'b0;
            #1 rst_obs = {short_press, long_press, repeat_press, key_hold};
         end else if (rst_at >= 0 && c == rst_at + 1) begin
            sys_rst_n = 1'b1;
         end
         @(negedge sys_clk);
         obs[c] = {short_press, long_press, repeat_press, key_hold};
         @(posedge sys_clk);
         #1;
      end
      key_flag = 1'b0;
   endtask

   task automatic mark(input int c, input int b, input int lim);
      if (c < lim && c < N) exp_o[c][b] = 1'b1;
   endtask

   // each accepted press: find the confirmed release (REL+1 released samples after acceptance),
   // compare it with the long threshold time, then emit the implied events
   task automatic model_seg(input int t0, input int t1, input int n);
      int t, x, run, lp;
      t = t0;
      while (t < t1) begin
         if (!stim_kf[t]) begin
            t++;
            continue;
         end
         x = n + 1000;
         run = 0;
         for (int k = t + 1; k < n; k++) begin
            run = bs[k] ? run + 1 : 0;
            if (run == REL + 1) begin
               x = k;
               break;
            end
         end
         lp = t + 1 + LNG;
         for (int h = t + 1; h <= x && h < t1; h++) exp_o[h][0] = 1'b1;
         if (x <= lp) begin
            mark(x + 1, 3, t1);
         end else begin
            mark(lp + 1, 2, t1);
            if (REP_EN)
               for (int p = lp + REP + 2; p <= x && p < t1; p += REP + 1) mark(p, 1, t1);
         end
         t = x + 1;
      end
   endtask

   task automatic model(input int n, input int rst_at);
      for (int c = 0; c < N; c++) begin
         exp_o[c] = 4'b0000;
         if (c < 2 || (rst_at >= 0 && c >= rst_at && c <= rst_at + 2)) bs[c] = 1'b1;
         else bs[c] = stim_btn[c - 2];
      end
      if (rst_at < 0) begin
         model_seg(0, n, n);
      end else begin
         model_seg(0, rst_at, n);
         model_seg(rst_at + 1, n, n);
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({short_press, long_press, repeat_press, key_hold} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs got %b exp 0000", {short_press, long_press, repeat_press, key_hold});
      end
      clear_stim();
      run_stim(20, -1);
      model(20, -1);
      for (int c = 0; c < 20; c++) begin
         n_cmp++;
         if (obs[c] !== exp_o[c]) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d got %b exp %b", c, obs[c], exp_o[c]);
         end
      end
   endtask

   task automatic test_short_press();
      clear_stim();
      set_btn(5, 14, 1'b0);
      stim_kf[10] = 1'b1;
      run_stim(40, -1);
      model(40, -1);
      for (int c = 0; c < 40; c++) begin
         n_cmp++;
         if (obs[c] !== exp_o[c]) begin
            n_fail++;
            $display("FAIL short_press cyc %0d got %b exp %b", c, obs[c], exp_o[c]);
         end
      end
      n_cmp++;
      if ({obs[10], obs[11], obs[20], obs[21]} !== {4'b0000, 4'b0001, 4'b0001, 4'b1000}) begin
         n_fail++;
         $display("FAIL short_press_timing got %b %b %b %b exp 0000 0001 0001 1000",
                  obs[10], obs[11], obs[20], obs[21]);
      end
   endtask

   task automatic test_long_repeat();
      clear_stim();
      set_btn(5, 49, 1'b0);
      stim_kf[10] = 1'b1;
      run_stim(70, -1);
      model(70, -1);
      for (int c = 0; c < 70; c++) begin
         n_cmp++;
         if (obs[c] !== exp_o[c]) begin
            n_fail++;
            $display("FAIL long_repeat cyc %0d got %b exp %b", c, obs[c], exp_o[c]);
         end
      end
      n_cmp++;
      if ({obs[32], obs[38], obs[50], obs[55], obs[56]} !==
          {4'b0101, 2'b00, REP_EN, 1'b1, 2'b00, REP_EN, 1'b1, 4'b0001, 4'b0000}) begin
         n_fail++;
         $display("FAIL long_repeat_timing got %b %b %b %b %b", obs[32], obs[38], obs[50], obs[55], obs[56]);
      end
   endtask

   task automatic test_release_bounce();
      int n_short;
      clear_stim();
      set_btn(5, 16, 1'b0);
      set_btn(19, 19, 1'b0);
      stim_kf[10] = 1'b1;
      run_stim(40, -1);
      model(40, -1);
      n_short = 0;
      for (int c = 0; c < 40; c++) begin
         n_short += int'(obs[c][3]);
         n_cmp++;
         if (obs[c] !== exp_o[c]) begin
            n_fail++;
            $display("FAIL release_bounce cyc %0d got %b exp %b", c, obs[c], exp_o[c]);
         end
      end
      n_cmp++;
      if (obs[26] !== 4'b1000 || n_short != 1) begin
         n_fail++;
         $display("FAIL release_bounce_short got %b count %0d exp 1000 count 1", obs[26], n_short);
      end
   endtask

   task automatic test_simultaneous();
      int n_long;
      clear_stim();
      set_btn(5, 25, 1'b0);
      stim_kf[10] = 1'b1;
      run_stim(45, -1);
      model(45, -1);
      n_long = 0;
      for (int c = 0; c < 45; c++) begin
         n_long += int'(obs[c][2]);
         n_cmp++;
         if (obs[c] !== exp_o[c]) begin
            n_fail++;
            $display("FAIL simultaneous cyc %0d got %b exp %b", c, obs[c], exp_o[c]);
         end
      end
      n_cmp++;
      if (obs[32] !== 4'b1000 || n_long != 0) begin
         n_fail++;
         $display("FAIL simultaneous_prio got %b long_count %0d exp 1000 long_count 0", obs[32], n_long);
      end
   endtask

   task automatic test_reset_mid_hold();
      clear_stim();
      set_btn(5, 53, 1'b0);
      stim_kf[10] = 1'b1;
      stim_kf[40] = 1'b1;
      run_stim(75, 35);
      model(75, 35);
      for (int c = 0; c < 75; c++) begin
         n_cmp++;
         if (obs[c] !== exp_o[c]) begin
            n_fail++;
            $display("FAIL reset_mid_hold cyc %0d got %b exp %b", c, obs[c], exp_o[c]);
         end
      end
      n_cmp++;
      if ({obs[34][0], rst_obs, obs[36], obs[41], obs[60]} !==
          {1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b1000}) begin
         n_fail++;
         $display("FAIL reset_mid_hold_spots got %b %b %b %b %b", obs[34][0], rst_obs, obs[36], obs[41], obs[60]);
      end
   endtask

   task automatic test_random();
      int t, hl, nb;
      for (int iter = 0; iter < 3; iter++) begin
         clear_stim();
         t = 4;
         while (t < N - 80) begin
            t += $urandom_range(1, 8);
            hl = $urandom_range(1, 45);
            set_btn(t, t + hl, 1'b0);
            stim_kf[t + $urandom_range(0, 2)] = 1'b1;
            t += hl + 1;
            nb = $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
               stim_btn[t] = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) stim_kf[t] = 1'b1;
               t++;
            end
            t += REL + 2 + $urandom_range(0, 6);
         end
         run_stim(N, -1);
         model(N, -1);
         for (int c = 0; c < N; c++) begin
            n_cmp++;
            if (obs[c] !== exp_o[c]) begin
               n_fail++;
               $display("FAIL random it %0d cyc %0d got %b exp %b", iter, c, obs[c], exp_o[c]);
            end
            n_cmp++;
            if ($countones(obs[c][3:1]) > 1) begin
               n_fail++;
               $display("FAIL one_hot_events it %0d cyc %0d got %b exp at most one pulse", iter, c, obs[c]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_repeat();
      test_release_bounce();
      test_simultaneous();
      test_reset_mid_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

endmodule
